aes_round_sequencer: RTL and testbench

Iterative AES-128 encryption controller. It accepts one 128-bit block over a valid/ready handshake and converts it from row-major to column-major byte order. It then steps an external single-round datapath through rounds 0..NR, fetches round keys by index, and returns the result in row-major order. It sits between the block I/O interface and the shared round-function/key-schedule logic.

---
 rtl/aes_round_sequencer_pkg.sv | 26 ++
 rtl/aes_round_sequencer_row2column.sv | 12 +
 rtl/aes_round_sequencer.sv | 151 +++++++++++++++
 tb/tb_aes_round_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_round_sequencer_pkg.sv
// Shared types and helpers for the iterative AES-128 round sequencer.
// Holds the FSM encoding, block geometry and the row/column byte transpose.
package aes_round_sequencer_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } seq_state_e;

  // Byte 4c+r of the result is byte 4r+c of the input; applying it twice is identity.
  function automatic logic [0:AES_BLK_W-1] transpose(input logic [0:AES_BLK_W-1] blk);
    logic [0:AES_BLK_W-1] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[8*(4*c+r) +: 8] = blk[8*(4*r+c) +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_row2column.sv
// Row-major <-> column-major byte transpose of one 128-bit AES block.
// Purely combinational; used on both the input and the output path.
module row2column
  import aes_round_sequencer_pkg::*;
(
  input  logic [0:AES_BLK_W-1] i_blk,
  output logic [0:AES_BLK_W-1] o_blk
);

  assign o_blk = transpose(i_blk);

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: accepts a row-major block, steps an external
// single-round datapath through rounds 0..NR, and returns the row-major result.
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
#(
  parameter int NR       = AES_NR,
  parameter int RK_IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:AES_BLK_W-1]  in_block,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:AES_BLK_W-1]  out_block,
  output logic [RK_IDX_W-1:0]   rk_idx,
  input  logic [0:AES_BLK_W-1]  rk_data,
  output logic [0:AES_BLK_W-1]  rnd_state_out,
  output logic                  rnd_last,
  input  logic [0:AES_BLK_W-1]  rnd_state_in,
  output logic                  busy
);

  localparam logic [RK_IDX_W-1:0] LP_NR  = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] LP_ONE = RK_IDX_W'(1);

  seq_state_e            r_state;
  seq_state_e            w_next_state;
  logic [0:AES_BLK_W-1]  r_st;
  logic [RK_IDX_W-1:0]   r_rnd;
  logic [0:AES_BLK_W-1]  w_in_tr;
  logic [0:AES_BLK_W-1]  w_out_tr;
  logic                  w_rnd_is_last;
  logic                  w_accept;
  logic                  w_release;

  row2column u_in_tr (
    .i_blk (in_block),
    .o_blk (w_in_tr)
  );

  row2column u_out_tr (
    .i_blk (r_st),
    .o_blk (w_out_tr)
  );

  assign w_rnd_is_last = (r_rnd == LP_NR);
  assign w_accept      = (r_state == S_IDLE) && in_valid;
  assign w_release     = (r_state == S_DONE) && out_ready;
  assign rnd_state_out = r_st;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_ROUND;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ROUND: begin
        if (w_rnd_is_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_ROUND;
        end
      end
      S_DONE: begin
        if (w_release) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM output decode; out_block only exposes the state once the block is finished
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = '0;
    rnd_last  = 1'b0;
    out_block = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_ROUND: begin
        busy     = 1'b1;
        rk_idx   = r_rnd;
        rnd_last = w_rnd_is_last;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_block = w_out_tr;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Block state and round counter; the initial AddRoundKey folds into the accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= '0;
      r_rnd <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_st  <= w_in_tr ^ rk_data;
            r_rnd <= LP_ONE;
          end
        end
        S_ROUND: begin
          r_st <= rnd_state_in;
          if (!w_rnd_is_last) begin
            r_rnd <= r_rnd + LP_ONE;
          end
        end
        S_DONE: begin
          if (w_release) begin
            r_rnd <= '0;
          end
        end
        default: begin
          r_st  <= '0;
          r_rnd <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: provides a behavioural AES
// round datapath / key schedule and compares against FIPS-197 and a reference model.
module tb_aes_round_sequencer;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_block;
  logic [3:0]   rk_idx;
  logic [0:127] rk_data;
  logic [0:127] rnd_state_out;
  logic         rnd_last;
  logic [0:127] rnd_state_in;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic         dp_aes;
  logic [7:0]   sbox [256];
  logic [0:127] rk_tab [11];

  aes_round_sequencer #(.NR(NR), .RK_IDX_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_block      (in_block),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_block     (out_block),
    .rk_idx        (rk_idx),
    .rk_data       (rk_data),
    .rnd_state_out (rnd_state_out),
    .rnd_last      (rnd_last),
    .rnd_state_in  (rnd_state_in),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench-local transpose (byte 4c+r <- byte 4r+c)
  function automatic logic [0:127] swap16(input logic [0:127] b);
    logic [0:127] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(4*c+r) +: 8] = b[8*(4*r+c) +: 8];
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // One AES round on a FIPS byte string (byte r+4c = state[r][c])
  function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] k,
                                            input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [0:127] o;
    o = '0;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[8*i +: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r+4*c] = a[r + 4*((c+r)%4)];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (last) o[8*(r+4*c) +: 8] = b[r+4*c];
        else o[8*(r+4*c) +: 8] = gmul(8'h02, b[r+4*c]) ^ gmul(8'h03, b[(r+1)%4+4*c])
                                  ^ b[(r+2)%4+4*c] ^ b[(r+3)%4+4*c];
    return o ^ k;
  endfunction

  task automatic load_key(input logic [0:127] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Reference: whole AES-128 encryption with the currently loaded key schedule
  function automatic logic [0:127] ref_encrypt(input logic [0:127] pt);
    logic [0:127] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, rk_tab[r], r == NR);
    return s;
  endfunction

  // External round datapath and key store; its bus is the transpose of FIPS byte order
  always_comb begin
    rk_data      = '0;
    rnd_state_in = rnd_state_out;
    if (dp_aes) begin
      if (rk_idx <= 4'd10) rk_data = swap16(rk_tab[rk_idx]);
      else rk_data = '0;
      rnd_state_in = swap16(aes_round(swap16(rnd_state_out), swap16(rk_data), rnd_last));
    end else begin
      rk_data = '0;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_out(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 128'(n), 128'(NR));
  endtask

  // Drives one block from IDLE with out_ready high and checks the result
  task automatic run_block(input logic [0:127] pt, input logic [0:127] key,
                           input logic [0:127] exp, input string nm);
    int n;
    load_key(key);
    out_ready = 1'b1;
    in_block  = pt;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " in_ready"}, 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(nm);
    chk({nm, " out_block"}, out_block, exp);
    @(posedge clk); #1;
    chk({nm, " released"}, 128'(busy), 128'(0));
  endtask

  typedef struct {
    logic [0:127] pt;
    logic [0:127] key;
    logic [0:127] ct;
  } vec_t;

  vec_t         vt [6];
  logic [0:127] pts [3];
  logic [0:127] exps [3];
  int           acc [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         lastcnt;
    logic [7:0] inv;
    logic [7:0] s;
    logic [0:127] k;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_block = '0; dp_aes = 1'b0;
    #12;
    chk("reset in_ready",  128'(in_ready),  128'(1));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset busy",      128'(busy),      128'(0));
    chk("reset rk_idx",    128'(rk_idx),    128'(0));
    chk("reset rnd_last",  128'(rnd_last),  128'(0));
    chk("reset out_block", out_block,       128'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Transpose round-trip with a pass-through datapath
    in_block = 128'h000102030405060708090a0b0c0d0e0f;
    in_valid = 1'b1;
    chk("rt idle rk_idx",   128'(rk_idx),   128'(0));
    chk("rt idle rnd_last", 128'(rnd_last), 128'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lastcnt = 0;
    for (int i = 1; i <= NR; i++) begin
      chk("rt rk_idx",   128'(rk_idx),   128'(i));
      chk("rt rnd_last", 128'(rnd_last), 128'(i == NR));
      chk("rt in_ready", 128'(in_ready), 128'(0));
      if (rnd_last) lastcnt++;
      @(posedge clk); #1;
    end
    chk("rt out_valid",   128'(out_valid), 128'(1));
    chk("rt out_block",   out_block, 128'h000102030405060708090a0b0c0d0e0f);
    chk("rt last count",  128'(lastcnt), 128'(1));
    chk("rt done last",   128'(rnd_last), 128'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rt back to idle", 128'(in_ready), 128'(1));

    // Table-driven known-answer and random vectors
    dp_aes = 1'b1;
    vt[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vt[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3925841d02dc09fbdc118597196a0b32};
    for (int i = 2; i < 6; i++) begin
      vt[i].pt  = {$urandom, $urandom, $urandom, $urandom};
      vt[i].key = {$urandom, $urandom, $urandom, $urandom};
      load_key(vt[i].key);
      vt[i].ct  = ref_encrypt(vt[i].pt);
    end
    for (int i = 0; i < 6; i++) run_block(vt[i].pt, vt[i].key, vt[i].ct, $sformatf("vec%0d", i));

    // Backpressure: result held while out_ready is low, offered blocks ignored
    load_key(vt[0].key);
    out_ready = 1'b0;
    in_block  = vt[0].pt;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", 128'(out_valid), 128'(1));
      chk("bp in_ready",  128'(in_ready),  128'(0));
      chk("bp out_block", out_block, vt[0].ct);
      in_valid = (i % 2 == 0);
      in_block = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp final block", out_block, vt[0].ct);
    @(posedge clk); #1;
    chk("bp idle busy",  128'(busy),     128'(0));
    chk("bp idle ready", 128'(in_ready), 128'(1));

    // Asynchronous reset in the middle of round 4
    in_block = vt[1].pt;
    load_key(vt[1].key);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid rk_idx before", 128'(rk_idx), 128'(4));
    #2 rst = 1'b1;
    #1;
    chk("mid in_ready",  128'(in_ready),  128'(1));
    chk("mid rk_idx",    128'(rk_idx),    128'(0));
    chk("mid busy",      128'(busy),      128'(0));
    chk("mid out_valid", 128'(out_valid), 128'(0));
    chk("mid out_block", out_block, 128'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_block(vt[0].pt, vt[0].key, vt[0].ct, "after reset");

    // Back-to-back: in_valid held high, three blocks
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k);
    for (int i = 0; i < 3; i++) begin
      pts[i]  = {$urandom, $urandom, $urandom, $urandom};
      exps[i] = ref_encrypt(pts[i]);
    end
    out_ready = 1'b1;
    in_block  = pts[0];
    in_valid  = 1'b1;
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (!in_ready && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b in_ready", 128'(in_ready), 128'(1));
      acc[b] = cyc;
      @(posedge clk); #1;
      if (b < 2) in_block = pts[b+1];
      else in_valid = 1'b0;
      wait_out("b2b");
      chk("b2b out_block", out_block, exps[b]);
      @(posedge clk); #1;
    end
    chk("b2b spacing 0-1", 128'(acc[1] - acc[0]), 128'(NR + 2));
    chk("b2b spacing 1-2", 128'(acc[2] - acc[1]), 128'(NR + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
